// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//
// Shares the register file's single write port between two write-back
// requesters and keeps a pending-write scoreboard for decode hazard checks.
// Port 0 is the main ALU pipeline; port 1 is a multi-cycle unit (mul/div,
// load return). Arbitration is round-robin over a one-bit last_grant pointer
// and uses a valid/ready handshake.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   wb0_valid/reg/data, wb0_ready   write-back requester 0 (ready is comb.)
//   wb1_valid/reg/data, wb1_ready   write-back requester 1 (ready is comb.)
//   reserve_valid, reserve_reg      decode reserves a destination register
//   reg_write, write_reg, write_data  registered register-file write port
//   busy                        bit i set = register i has a pending write

module regfile_wb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wb0_valid,
  input  logic [ADDR_WIDTH-1:0]      wb0_reg,
  input  logic [DATA_WIDTH-1:0]      wb0_data,
  output logic                       wb0_ready,
  input  logic                       wb1_valid,
  input  logic [ADDR_WIDTH-1:0]      wb1_reg,
  input  logic [DATA_WIDTH-1:0]      wb1_data,
  output logic                       wb1_ready,
  input  logic                       reserve_valid,
  input  logic [ADDR_WIDTH-1:0]      reserve_reg,
  output logic                       reg_write,
  output logic [ADDR_WIDTH-1:0]      write_reg,
  output logic [DATA_WIDTH-1:0]      write_data,
  output logic [(2**ADDR_WIDTH)-1:0] busy
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic                  last_grant;
  logic                  xfer;
  logic [ADDR_WIDTH-1:0] sel_reg;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [NUM_REGS-1:0]   busy_next;

  // Round-robin grant: a lone valid port always wins; under contention the
  // port that did not win last time gets ready. Depends only on the valids
  // and last_grant so there is no path from the write-port outputs back in.
  always_comb begin
    wb0_ready = wb0_valid & (~wb1_valid | last_grant);
    wb1_ready = wb1_valid & (~wb0_valid | ~last_grant);
    xfer      = wb0_ready | wb1_ready;
    sel_reg   = wb1_ready ? wb1_reg  : wb0_reg;
    sel_data  = wb1_ready ? wb1_data : wb0_data;
  end

  // Scoreboard next state. The clear is applied before the set so that a
  // reservation landing on the same register as a completing write wins and
  // the bit stays pending for the new producer. Register 0 never goes busy.
  always_comb begin
    busy_next = busy;
    if (xfer && (sel_reg != '0)) begin
      busy_next[sel_reg] = 1'b0;
    end
    if (reserve_valid && (reserve_reg != '0)) begin
      busy_next[reserve_reg] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // Registered write port, arbitration pointer and scoreboard. A transfer to
  // register 0 is still accepted (and moves the pointer) but never raises
  // reg_write. Reset starts last_grant at 1 so port 0 wins first contention.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
      reg_write  <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
      busy       <= '0;
    end else begin
      busy <= busy_next;
      if (xfer) begin
        last_grant <= wb1_ready;
        reg_write  <= (sel_reg != '0);
        write_reg  <= sel_reg;
        write_data <= sel_data;
      end else begin
        reg_write <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter
//
// Directed, table-driven bench for regfile_wb_arbiter. Each table row holds
// one cycle of inputs plus the expected readies (before the edge) and the
// expected write port / scoreboard (after the edge). A hand-written sequence
// afterwards covers the asynchronous mid-stream reset and first grant after it.

module tb_regfile_wb_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NV = 21;

  logic          clk;
  logic          reset;
  logic          wb0_valid;
  logic [AW-1:0] wb0_reg;
  logic [DW-1:0] wb0_data;
  logic          wb0_ready;
  logic          wb1_valid;
  logic [AW-1:0] wb1_reg;
  logic [DW-1:0] wb1_data;
  logic          wb1_ready;
  logic          reserve_valid;
  logic [AW-1:0] reserve_reg;
  logic          reg_write;
  logic [AW-1:0] write_reg;
  logic [DW-1:0] write_data;
  logic [31:0]   busy;

  int compared;
  int mismatched;

  typedef struct {
    logic          v0;
    logic [AW-1:0] r0;
    logic [DW-1:0] d0;
    logic          v1;
    logic [AW-1:0] r1;
    logic [DW-1:0] d1;
    logic          rv;
    logic [AW-1:0] rr;
    logic          e_rdy0;
    logic          e_rdy1;
    logic          e_rw;
    logic [AW-1:0] e_wr;
    logic [DW-1:0] e_wd;
    logic [31:0]   e_busy;
  } vec_t;

  vec_t vecs [NV];

  regfile_wb_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk           (clk),
    .reset         (reset),
    .wb0_valid     (wb0_valid),
    .wb0_reg       (wb0_reg),
    .wb0_data      (wb0_data),
    .wb0_ready     (wb0_ready),
    .wb1_valid     (wb1_valid),
    .wb1_reg       (wb1_reg),
    .wb1_data      (wb1_data),
    .wb1_ready     (wb1_ready),
    .reserve_valid (reserve_valid),
    .reserve_reg   (reserve_reg),
    .reg_write     (reg_write),
    .write_reg     (write_reg),
    .write_data    (write_data),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic v0, input logic [AW-1:0] r0, input logic [DW-1:0] d0,
    input logic v1, input logic [AW-1:0] r1, input logic [DW-1:0] d1,
    input logic rv, input logic [AW-1:0] rr,
    input logic e_rdy0, input logic e_rdy1,
    input logic e_rw, input logic [AW-1:0] e_wr, input logic [DW-1:0] e_wd,
    input logic [31:0] e_busy);
    vec_t v;
    v.v0 = v0; v.r0 = r0; v.d0 = d0;
    v.v1 = v1; v.r1 = r1; v.d1 = d1;
    v.rv = rv; v.rr = rr;
    v.e_rdy0 = e_rdy0; v.e_rdy1 = e_rdy1;
    v.e_rw = e_rw; v.e_wr = e_wr; v.e_wd = e_wd;
    v.e_busy = e_busy;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    wb0_valid     = v.v0;
    wb0_reg       = v.r0;
    wb0_data      = v.d0;
    wb1_valid     = v.v1;
    wb1_reg       = v.r1;
    wb1_data      = v.d1;
    reserve_valid = v.rv;
    reserve_reg   = v.rr;
  endtask

  task automatic idleInputs();
    wb0_valid = 0; wb0_reg = '0; wb0_data = '0;
    wb1_valid = 0; wb1_reg = '0; wb1_data = '0;
    reserve_valid = 0; reserve_reg = '0;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    idleInputs();

    //       v0 r0  d0            v1 r1 d1            rv rr  rdy0 rdy1 rw wr  wd            busy
    vecs[0]  = mk(0, 0,  32'h0,        0, 0, 32'h0,        0, 0,  0, 0, 0, 0,  32'h0,        32'h0);
    vecs[1]  = mk(0, 0,  32'h0,        1, 5, 32'hDEADBEEF, 0, 0,  0, 1, 1, 5,  32'hDEADBEEF, 32'h0);
    vecs[2]  = mk(0, 0,  32'h0,        0, 0, 32'h0,        0, 0,  0, 0, 0, 0,  32'h0,        32'h0);
    vecs[3]  = mk(1, 3,  32'hA0000000, 1, 4, 32'hB0000000, 0, 0,  1, 0, 1, 3,  32'hA0000000, 32'h0);
    vecs[4]  = mk(1, 3,  32'hA0000001, 1, 4, 32'hB0000000, 0, 0,  0, 1, 1, 4,  32'hB0000000, 32'h0);
    vecs[5]  = mk(1, 3,  32'hA0000001, 1, 4, 32'hB0000001, 0, 0,  1, 0, 1, 3,  32'hA0000001, 32'h0);
    vecs[6]  = mk(1, 3,  32'hA0000002, 1, 4, 32'hB0000001, 0, 0,  0, 1, 1, 4,  32'hB0000001, 32'h0);
    vecs[7]  = mk(0, 0,  32'h0,        0, 0, 32'h0,        0, 0,  0, 0, 0, 0,  32'h0,        32'h0);
    vecs[8]  = mk(1, 0,  32'h1,        0, 0, 32'h0,        0, 0,  1, 0, 0, 0,  32'h0,        32'h0);
    vecs[9]  = mk(1, 3,  32'hC0000000, 1, 4, 32'hD0000000, 0, 0,  0, 1, 1, 4,  32'hD0000000, 32'h0);
    vecs[10] = mk(1, 3,  32'hC0000000, 0, 0, 32'h0,        0, 0,  1, 0, 1, 3,  32'hC0000000, 32'h0);
    vecs[11] = mk(0, 0,  32'h0,        0, 0, 32'h0,        1, 7,  0, 0, 0, 0,  32'h0,        32'h80);
    vecs[12] = mk(0, 0,  32'h0,        1, 7, 32'hE0000000, 1, 7,  0, 1, 1, 7,  32'hE0000000, 32'h80);
    vecs[13] = mk(1, 7,  32'hE0000001, 0, 0, 32'h0,        0, 0,  1, 0, 1, 7,  32'hE0000001, 32'h0);
    vecs[14] = mk(0, 0,  32'h0,        0, 0, 32'h0,        1, 0,  0, 0, 0, 0,  32'h0,        32'h0);
    vecs[15] = mk(0, 0,  32'h0,        0, 0, 32'h0,        1, 7,  0, 0, 0, 0,  32'h0,        32'h80);
    vecs[16] = mk(0, 0,  32'h0,        1, 7, 32'hF0000000, 1, 9,  0, 1, 1, 7,  32'hF0000000, 32'h200);
    vecs[17] = mk(0, 0,  32'h0,        0, 0, 32'h0,        1, 2,  0, 0, 0, 0,  32'h0,        32'h204);
    vecs[18] = mk(0, 0,  32'h0,        0, 0, 32'h0,        1, 9,  0, 0, 0, 0,  32'h0,        32'h204);
    vecs[19] = mk(1, 12, 32'h12121212, 0, 0, 32'h0,        0, 0,  1, 0, 1, 12, 32'h12121212, 32'h204);
    vecs[20] = mk(0, 0,  32'h0,        1, 9, 32'h00000055, 1, 8,  0, 1, 1, 9,  32'h00000055, 32'h104);

    // Power-on reset: outputs must clear without any clock edge.
    reset = 1'b1;
    #2;
    checkOutput("por_reg_write", {31'h0, reg_write}, 32'h0);
    checkOutput("por_busy", busy, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d_wb0_ready", i), {31'h0, wb0_ready}, {31'h0, vecs[i].e_rdy0});
      checkOutput($sformatf("v%0d_wb1_ready", i), {31'h0, wb1_ready}, {31'h0, vecs[i].e_rdy1});
      @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d_reg_write", i), {31'h0, reg_write}, {31'h0, vecs[i].e_rw});
      if (vecs[i].e_rw) begin
        checkOutput($sformatf("v%0d_write_reg", i), {27'h0, write_reg}, {27'h0, vecs[i].e_wr});
        checkOutput($sformatf("v%0d_write_data", i), write_data, vecs[i].e_wd);
      end
      checkOutput($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
    end

    // Mid-stream asynchronous reset while reg_write=1 and busy=0x104.
    #2;
    idleInputs();
    reset = 1'b1;
    #1;
    checkOutput("mid_reset_reg_write", {31'h0, reg_write}, 32'h0);
    checkOutput("mid_reset_write_reg", {27'h0, write_reg}, 32'h0);
    checkOutput("mid_reset_write_data", write_data, 32'h0);
    checkOutput("mid_reset_busy", busy, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // First contention after reset must go to port 0.
    @(negedge clk);
    wb0_valid = 1; wb0_reg = 10; wb0_data = 32'h11111111;
    wb1_valid = 1; wb1_reg = 11; wb1_data = 32'h22222222;
    #1;
    checkOutput("post_reset_wb0_ready", {31'h0, wb0_ready}, 32'h1);
    checkOutput("post_reset_wb1_ready", {31'h0, wb1_ready}, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("post_reset_reg_write", {31'h0, reg_write}, 32'h1);
    checkOutput("post_reset_write_reg", {27'h0, write_reg}, 32'd10);
    checkOutput("post_reset_write_data", write_data, 32'h11111111);

    // Port 1 has been waiting, so it now wins; then the port idles.
    @(negedge clk);
    wb0_data = 32'h33333333;
    #1;
    checkOutput("post_reset2_wb1_ready", {31'h0, wb1_ready}, 32'h1);
    @(posedge clk);
    #1;
    checkOutput("post_reset2_write_reg", {27'h0, write_reg}, 32'd11);
    @(negedge clk);
    idleInputs();
    @(posedge clk);
    #1;
    checkOutput("post_reset_idle_reg_write", {31'h0, reg_write}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
